// File: rtl/mchan_rr_arb_pipe_pkg.sv
// Shared constants and width helpers for the multi-channel round-robin arbiter pipe.
package mchan_arb_pkg;

  localparam int N_CH_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ID_WIDTH_DEF   = 4;

  // A channel index needs at least one bit even when N_CH would need zero.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mchan_rr_arb_pipe_if.sv
// Upstream per-channel request bundle plus the registered downstream beat.
interface mchan_rr_arb_pipe_if
  import mchan_arb_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) ();

  localparam int SRC_WIDTH = src_width(N_CH);

  logic [N_CH-1:0]                 req_i;
  logic [N_CH-1:0]                 gnt_o;
  logic [N_CH-1:0]                 lock_i;
  logic [N_CH-1:0][DATA_WIDTH-1:0] data_i;
  logic [N_CH-1:0][ID_WIDTH-1:0]   id_i;
  logic                            req_o;
  logic                            gnt_i;
  logic [DATA_WIDTH-1:0]           data_o;
  logic [ID_WIDTH-1:0]             id_o;
  logic [SRC_WIDTH-1:0]            src_o;

  modport master (
    output req_i, lock_i, data_i, id_i, gnt_i,
    input  gnt_o, req_o, data_o, id_o, src_o
  );

  modport slave (
    input  req_i, lock_i, data_i, id_i, gnt_i,
    output gnt_o, req_o, data_o, id_o, src_o
  );

endinterface

// File: rtl/mchan_rr_arb_pipe_prio_sel.sv
// Combinational rotating first-one search: first set req bit at ptr, ptr+1, ... mod N_CH.
module mchan_rr_prio_sel #(
  parameter int N_CH      = 4,
  parameter int SRC_WIDTH = 2
) (
  input  logic [N_CH-1:0]      req,
  input  logic [SRC_WIDTH-1:0] ptr,
  output logic                 vld,
  output logic [SRC_WIDTH-1:0] win
);

  logic [SRC_WIDTH:0]   sum;
  logic [SRC_WIDTH-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    vld = 1'b0;
    win = '0;
    sum = '0;
    idx = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (SRC_WIDTH + 1)'(off);
      if (sum >= (SRC_WIDTH + 1)'(N_CH)) begin
        sum = sum - (SRC_WIDTH + 1)'(N_CH);
      end
      idx = sum[SRC_WIDTH-1:0];
      if (req[idx]) begin
        vld = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mchan_rr_arb_pipe.sv
// Round-robin N_CH:1 arbiter with lockable bursts into a single output register.
// One cycle grant-to-req_o latency; grants only while the output slot is empty or draining.
module mchan_rr_arb_pipe
  import mchan_arb_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  mchan_rr_arb_pipe_if.slave bus
);

  localparam int SRC_WIDTH = src_width(N_CH);

  logic [SRC_WIDTH-1:0]  ptr;
  logic [SRC_WIDTH-1:0]  ptr_nxt;
  logic [SRC_WIDTH-1:0]  win;
  logic                  win_vld;
  logic                  slot_free;
  logic                  xfer;
  logic [N_CH-1:0]       gnt;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [SRC_WIDTH-1:0]  src_q;

  mchan_rr_prio_sel #(
    .N_CH      (N_CH),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_prio_sel (
    .req (bus.req_i),
    .ptr (ptr),
    .vld (win_vld),
    .win (win)
  );

  assign slot_free = ~req_q | bus.gnt_i;
  assign xfer      = win_vld & slot_free & ~rst_i;

  always_comb begin
    gnt = '0;
    if (xfer) begin
      gnt[win] = 1'b1;
    end
  end

  // A locked winner keeps priority; otherwise priority moves just past it.
  always_comb begin
    ptr_nxt = ptr;
    if (bus.lock_i[win]) begin
      ptr_nxt = win;
    end else if (win == SRC_WIDTH'(N_CH - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = win + SRC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr    <= '0;
      req_q  <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      src_q  <= '0;
    end else begin
      if (xfer) begin
        ptr    <= ptr_nxt;
        req_q  <= 1'b1;
        data_q <= bus.data_i[win];
        id_q   <= bus.id_i[win];
        src_q  <= win;
      end else if (bus.gnt_i) begin
        req_q  <= 1'b0;
      end
    end
  end

  assign bus.gnt_o  = gnt;
  assign bus.req_o  = req_q;
  assign bus.data_o = data_q;
  assign bus.id_o   = id_q;
  assign bus.src_o  = src_q;

endmodule

// File: tb/tb_mchan_rr_arb_pipe.sv
// Scoreboarded directed and random checks of the arbiter pipe at N_CH = 4, 3 and 5.
module tb_mchan_rr_arb_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [4:0]  src;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mchan_rr_arb_pipe_if #(.N_CH(4), .DATA_WIDTH(32), .ID_WIDTH(4)) bus4 ();
  mchan_rr_arb_pipe_if #(.N_CH(3), .DATA_WIDTH(32), .ID_WIDTH(4)) bus3 ();
  mchan_rr_arb_pipe_if #(.N_CH(5), .DATA_WIDTH(32), .ID_WIDTH(4)) bus5 ();

  mchan_rr_arb_pipe #(.N_CH(4), .DATA_WIDTH(32), .ID_WIDTH(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
  mchan_rr_arb_pipe #(.N_CH(3), .DATA_WIDTH(32), .ID_WIDTH(4)) u3 (.clk_i(clk), .rst_i(rst), .bus(bus3));
  mchan_rr_arb_pipe #(.N_CH(5), .DATA_WIDTH(32), .ID_WIDTH(4)) u5 (.clk_i(clk), .rst_i(rst), .bus(bus5));

  int          sel;
  int          n;
  logic [31:0] t_req;
  logic [31:0] t_lock;
  logic        t_gnt;
  logic [31:0] t_data [32];
  logic [3:0]  t_id   [32];

  always_comb begin
    bus4.req_i  = (sel == 0) ? t_req[3:0]  : '0;
    bus4.lock_i = (sel == 0) ? t_lock[3:0] : '0;
    bus4.gnt_i  = (sel == 0) && t_gnt;
    bus4.data_i = '0;
    bus4.id_i   = '0;
    for (int k = 0; k < 4; k++) begin
      bus4.data_i[k] = t_data[k];
      bus4.id_i[k]   = t_id[k];
    end
  end

  always_comb begin
    bus3.req_i  = (sel == 1) ? t_req[2:0]  : '0;
    bus3.lock_i = (sel == 1) ? t_lock[2:0] : '0;
    bus3.gnt_i  = (sel == 1) && t_gnt;
    bus3.data_i = '0;
    bus3.id_i   = '0;
    for (int k = 0; k < 3; k++) begin
      bus3.data_i[k] = t_data[k];
      bus3.id_i[k]   = t_id[k];
    end
  end

  always_comb begin
    bus5.req_i  = (sel == 2) ? t_req[4:0]  : '0;
    bus5.lock_i = (sel == 2) ? t_lock[4:0] : '0;
    bus5.gnt_i  = (sel == 2) && t_gnt;
    bus5.data_i = '0;
    bus5.id_i   = '0;
    for (int k = 0; k < 5; k++) begin
      bus5.data_i[k] = t_data[k];
      bus5.id_i[k]   = t_id[k];
    end
  end

  logic [31:0] o_gnt;
  logic        o_req;
  logic [31:0] o_data;
  logic [3:0]  o_id;
  logic [4:0]  o_src;

  always_comb begin
    o_gnt  = '0;
    o_req  = 1'b0;
    o_data = '0;
    o_id   = '0;
    o_src  = '0;
    case (sel)
      0: begin
        o_gnt[3:0] = bus4.gnt_o; o_req = bus4.req_o; o_data = bus4.data_o;
        o_id = bus4.id_o; o_src = 5'(bus4.src_o);
      end
      1: begin
        o_gnt[2:0] = bus3.gnt_o; o_req = bus3.req_o; o_data = bus3.data_o;
        o_id = bus3.id_o; o_src = 5'(bus3.src_o);
      end
      default: begin
        o_gnt[4:0] = bus5.gnt_o; o_req = bus5.req_o; o_data = bus5.data_o;
        o_id = bus5.id_o; o_src = 5'(bus5.src_o);
      end
    endcase
  end

  int          total;
  int          bad;
  int          m_ptr;
  logic        m_vld;
  beat_t       sb [$];
  int          last_w;
  logic [31:0] obs_gnt;
  int          wcnt [5];
  int          max_wait;
  int          e35 [5] = '{0, 1, 2, 3, 0};
  int          e38 [7] = '{1, 1, 1, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int win_of(input logic [31:0] r, input int p, input int nn);
    for (int o = 0; o < nn; o++) begin
      if (r[(p + o) % nn]) return (p + o) % nn;
    end
    return -1;
  endfunction

  // One cycle: inputs already driven at the negedge; checks, model update, wait for next negedge.
  task automatic cyc();
    int          w;
    logic        xf;
    logic [31:0] exp_gnt;
    beat_t       b;
    #1;
    w       = win_of(t_req, m_ptr, n);
    xf      = (w >= 0) && (!m_vld || t_gnt);
    exp_gnt = xf ? (32'd1 << w) : 32'd0;
    obs_gnt = o_gnt;
    chk("gnt_o", o_gnt, exp_gnt);
    chk("req_o", o_req, m_vld);
    if (m_vld) begin
      chk("sb_has_beat", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        b = sb[0];
        chk("data_o", o_data, b.data);
        chk("id_o", o_id, b.id);
        chk("src_o", o_src, b.src);
        if (t_gnt) void'(sb.pop_front());
      end
    end
    if (xf) begin
      b.data = t_data[w];
      b.id   = t_id[w];
      b.src  = 5'(w);
      sb.push_back(b);
      m_ptr = t_lock[w] ? w : (w + 1) % n;
      m_vld = 1'b1;
    end else if (t_gnt) begin
      m_vld = 1'b0;
    end
    last_w = xf ? w : -1;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; n = 4; m_ptr = 0; m_vld = 1'b0; last_w = -1;
    max_wait = 0; obs_gnt = '0;
    rst = 1'b1; t_req = '0; t_lock = '0; t_gnt = 1'b0;
    for (int k = 0; k < 32; k++) begin
      t_data[k] = 32'h100 + k;
      t_id[k]   = 4'(k);
    end
    for (int k = 0; k < 5; k++) wcnt[k] = 0;

    // Reset state, with every channel requesting.
    t_req = 32'hF;
    #2;
    chk("rst_gnt_o", o_gnt, 0);
    chk("rst_req_o", o_req, 0);
    chk("rst_data_o", o_data, 0);
    chk("rst_id_o", o_id, 0);
    chk("rst_src_o", o_src, 0);
    @(negedge clk);
    t_req = '0; rst = 1'b0;
    @(negedge clk);

    // All four requesting, downstream always ready.
    t_req = 32'hF; t_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_src", o_src, 5'(e35[i]));
      chk("rr_req", o_req, 1);
    end
    t_req = '0;
    cyc();
    cyc();

    // Single beat from ch2 stalled three cycles while ch2 keeps requesting new data.
    t_data[2] = 32'hA5; t_id[2] = 4'h9; t_req = 32'h4; t_gnt = 1'b0;
    cyc();
    t_data[2] = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_data", o_data, 32'hA5);
      chk("stall_src", o_src, 2);
      chk("stall_req", o_req, 1);
    end
    t_req = '0; t_gnt = 1'b1;
    cyc();
    chk("stall_left", o_req, 0);

    // Bring priority to ch1, then lock ch1 for four beats and release by dropping its request.
    t_req = 32'h1;
    cyc();
    t_req = 32'hF; t_lock = 32'h2;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        t_req = 32'hD; t_lock = '0;
      end
      cyc();
      chk("lock_src", o_src, 5'(e38[i]));
    end
    t_req = '0;
    cyc();

    // Reset while a beat is held.
    t_data[2] = 32'hC3; t_req = 32'h4; t_gnt = 1'b0;
    cyc();
    chk("pre_rst_req", o_req, 1);
    t_req = 32'hF;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_o", o_req, 0);
    chk("mid_rst_data_o", o_data, 0);
    chk("mid_rst_id_o", o_id, 0);
    chk("mid_rst_src_o", o_src, 0);
    chk("mid_rst_gnt_o", o_gnt, 0);
    sb.delete(); m_vld = 1'b0; m_ptr = 0;
    @(negedge clk);
    rst = 1'b0; t_req = 32'hA; t_gnt = 1'b1;
    cyc();
    chk("post_rst_src", o_src, 1);
    t_req = '0;
    cyc();

    // Non-power-of-two wrap at N_CH = 3.
    sel = 1; n = 3; m_ptr = 0; m_vld = 1'b0; sb.delete();
    t_gnt = 1'b1; t_req = 32'h5;
    cyc();
    chk("wrap_src0", o_src, 0);
    cyc();
    chk("wrap_src2", o_src, 2);
    t_req = 32'h7;
    cyc();
    chk("wrap_src_next", o_src, 0);
    t_req = '0;
    cyc();

    // Random traffic at N_CH = 5 with persistent requesters.
    sel = 2; n = 5; m_ptr = 0; m_vld = 1'b0; sb.delete(); last_w = -1; t_lock = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 5; k++) begin
        if (t_req[k] && last_w != k) t_req[k] = ($urandom_range(0, 15) != 0);
        else t_req[k] = ($urandom_range(0, 1) == 1);
        t_data[k] = 32'(c * 256 + k);
        t_id[k]   = 4'(c + k);
      end
      t_gnt = ($urandom_range(0, 3) != 0);
      cyc();
      chk("onehot_gnt", $countones(obs_gnt) <= 1, 1);
      for (int k = 0; k < 5; k++) begin
        if (!t_req[k] || obs_gnt[k]) begin
          wcnt[k] = 0;
        end else if (obs_gnt != 0) begin
          wcnt[k]++;
          if (wcnt[k] > max_wait) max_wait = wcnt[k];
        end
      end
    end
    t_req = '0; t_gnt = 1'b1;
    cyc();
    cyc();
    chk("sb_drained", sb.size(), 0);
    chk("starve_bound", max_wait <= n - 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mchan_rr_arb_pipe.md
MCHAN_RR_ARB_PIPE -- requirements
Module: mchan_rr_arb_pipe

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, legal range 2..32, not restricted to powers of two.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width.
REQ-003 SHALL have parameter ID_WIDTH, default 4: transaction ID width.
REQ-004 SHALL derive constant SRC_WIDTH = max(1, clog2(N_CH)).
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req_i, input, N_CH bits: per-channel request.
REQ-008 SHALL have port gnt_o, output, N_CH bits: per-channel grant, at most one bit high.
REQ-009 SHALL have port lock_i, input, N_CH bits: per-channel burst lock, sampled with req_i.
REQ-010 SHALL have port data_i, input, N_CH x DATA_WIDTH bits: per-channel payload.
REQ-011 SHALL have port id_i, input, N_CH x ID_WIDTH bits: per-channel ID.
REQ-012 SHALL have port req_o, output, 1 bit: registered output request.
REQ-013 SHALL have port gnt_i, input, 1 bit: downstream grant.
REQ-014 SHALL have port data_o, output, DATA_WIDTH bits: registered payload.
REQ-015 SHALL have port id_o, output, ID_WIDTH bits: registered ID.
REQ-016 SHALL have port src_o, output, SRC_WIDTH bits: index of the winning channel, registered.

Function
REQ-017 SHALL compute the winner as the first channel with req_i high, scanning ptr, ptr+1, ... modulo N_CH.
REQ-018 SHALL define slot_free = ~req_o | gnt_i, meaning the output register is empty or is being drained this cycle.
REQ-019 SHALL drive gnt_o[winner] = slot_free, combinationally; all other gnt_o bits SHALL be 0, and gnt_o SHALL be 0 when req_i is 0.
REQ-020 SHALL perform an input transfer when a gnt_o bit is high; on that edge req_o<=1 and data_o, id_o, src_o are loaded from the winner.
REQ-021 SHALL have a latency of exactly 1 cycle from the input transfer to req_o, with throughput of 1 transfer per cycle while gnt_i stays high.
REQ-022 SHALL hold req_o, data_o, id_o and src_o stable while req_o=1 and gnt_i=0.
REQ-023 SHALL clear req_o on gnt_i=1 when no input transfer occurs in the same cycle.
REQ-024 SHALL, on an input transfer from channel k, set ptr<=k if lock_i[k]=1, else ptr<=(k+1) mod N_CH; ptr SHALL be unchanged on cycles with no transfer.
REQ-025 SHALL wrap ptr from N_CH-1 to 0 for any N_CH, including non-power-of-two values.
REQ-026 SHALL release priority when a locked channel drops req_i, the scan then resuming from the current ptr.
REQ-027 SHALL leave requesters un-granted while stalled; a requester may change or deassert req_i without loss.
REQ-028 SHALL guarantee that any continuously requesting unlocked channel is granted within N_CH transfers.

Reset
REQ-029 SHALL, on rst_i high, asynchronously set req_o=0, data_o=0, id_o=0, src_o=0 and ptr=0.
REQ-030 SHALL force gnt_o=0 during reset, regardless of req_i.
REQ-031 SHALL discard a held output beat on reset mid-transfer, and the first post-reset scan SHALL start at channel 0.

Structure
REQ-032 SHALL place SRC_WIDTH derivation helpers and the default parameter constants in shared package mchan_arb_pkg.
REQ-033 SHALL implement the rotating first-one search as a combinational sub-module mchan_rr_prio_sel, with inputs req and ptr and outputs a valid flag and a winner index.
REQ-034 SHALL contain only ptr and the output register as state; no other storage.

Verification
REQ-035 SHALL test: N_CH=4, req_i=1111, gnt_i=1 constantly -> src_o sequence 0,1,2,3,0, one per cycle, first req_o one cycle after the first gnt_o.
REQ-036 SHALL test: one beat from ch2 with data 0xA5, gnt_i=0 for 3 cycles -> data_o=0xA5, src_o=2, req_o=1 held for 3 cycles; gnt_o=0 throughout; beat leaves on the 4th cycle.
REQ-037 SHALL test: N_CH=3, req_i=101, then 111 after ch2 wins -> ptr wraps to 0 and the next winner is ch0.
REQ-038 SHALL test: N_CH=4, ch1 with lock_i=1 for 4 beats while req_i=1111 -> src_o=1 four times, then 2,3,0.
REQ-039 SHALL test: rst_i asserted while req_o=1 and gnt_i=0 -> req_o=0 and all outputs 0 immediately; the next grant goes to the lowest requesting channel.
REQ-040 SHALL test: random req_i/gnt_i over 10k cycles, N_CH=5 -> no beat lost or duplicated, at most one gnt_o bit high, starvation bound per REQ-028 holds.
